// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts a word through a valid/ready handshake and
// emits its low L bits MSB-first, one per clock, with gapless back-to-back words.
module serial_bit_feeder #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = $clog2(WIDTH + 1),
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO     = LEN_W'(2);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] cnt;    // bits of the current word still to show, including the one on serial_out

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             take;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    eff_len = (load_len > WIDTH_L) ? WIDTH_L : load_len;
    // Left-align the word so its bit L-1 sits at the shift register MSB.
    aligned = load_data << (WIDTH_L - eff_len);
    // A zero-length word completes the handshake but is otherwise dropped.
    take    = load_valid && load_ready && (eff_len != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      serial_out   <= IDLE_BIT;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_ready   <= 1'b0;
    end else if (take) begin
      state        <= SHIFT;
      serial_out   <= aligned[WIDTH-1];
      shreg        <= aligned << 1;
      cnt          <= eff_len;
      serial_valid <= 1'b1;
      busy         <= 1'b1;
      done         <= (eff_len == ONE);
      load_ready   <= (eff_len == ONE);
    end else if (state == SHIFT) begin
      if (cnt == ONE) begin
        state        <= IDLE;
        serial_out   <= IDLE_BIT;
        serial_valid <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        load_ready   <= 1'b1;
      end else begin
        serial_out   <= shreg[WIDTH-1];
        shreg        <= shreg << 1;
        cnt          <= cnt - ONE;
        done         <= (cnt == TWO);
        load_ready   <= (cnt == TWO);
      end
    end else begin
      load_ready <= 1'b1;
    end
  end

endmodule
